ram_arbiter: RTL and testbench

Two-requester arbiter that shares the 256-byte `ram` (separate read and write ports: `w_sig`, `add_w`, `din`, `add_r`, `dout`) between two clients. The write port and the read port are arbitrated independently with round-robin fairness, so one client can write while the other reads in the same cycle. The arbiter returns read data with a fixed one-cycle latency and forwards same-cycle write data on address collisions. It sits between the client logic and the `ram` instance.

---
 rtl/ram_arb_pkg.sv | 39 +++
 rtl/ram_arbiter_rr_arb2.sv | 44 ++++
 rtl/ram_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_pkg
// Purpose: Shared definitions for the two-client RAM arbiter: default data
//          and address widths, RAM word/address types, the client index
//          type and the 2-way round-robin pick function.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

  localparam int unsigned RAM_DW = 8;  // RAM word width
  localparam int unsigned RAM_AW = 8;  // RAM address width (256 words)

  typedef logic [RAM_AW-1:0] ram_addr_t;
  typedef logic [RAM_DW-1:0] ram_data_t;

  // Client index; also used as the round-robin priority pointer.
  typedef enum logic {
    CLIENT0 = 1'b0,
    CLIENT1 = 1'b1
  } client_t;

  // One-hot grant for a 2-bit request vector. Under contention the pointer
  // holder wins; a lone requester always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input client_t ptr);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (ptr == CLIENT1) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Purpose: Two-way round-robin arbiter with a 1-bit priority pointer. The
//          grant is combinational; the pointer moves to the losing client
//          after every grant and holds when nothing is granted.
// Ports  : clk  in   clock (rising edge)
//          rst  in   synchronous active-high reset (pointer -> client 0)
//          req  in   [1:0] request per client
//          gnt  out  [1:0] one-hot grant, same cycle as req
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  client_t ptr_q, ptr_d;

  always_comb begin
    gnt   = rr_pick(req, ptr_q);
    ptr_d = ptr_q;
    // Hand priority to whichever client did not get this grant.
    if (gnt[0]) begin
      ptr_d = CLIENT1;
    end else if (gnt[1]) begin
      ptr_d = CLIENT0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= CLIENT0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ram_arbiter
// Purpose: Shares a dual-port (1W + 1R) RAM between two clients. Write and
//          read ports are arbitrated independently with round-robin
//          fairness. Read data returns one cycle after acceptance; a read and
//          write to the same address in the same cycle returns the new data.
// Ports  : clk, rst                 clock, synchronous active-high reset
//          reqN, weN, addrN, wdataN client N request (N = 0,1)
//          ackN                     combinational accept
//          rvalidN, rdataN          registered read response (rdata 0 if idle)
//          ram_w_sig, ram_add_w,
//          ram_din, ram_add_r       RAM command outputs
//          ram_dout                 RAM read data (one cycle after ram_add_r)
// Rev    : 1.0  initial release
// ============================================================================
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW = RAM_DW,
  parameter int unsigned AW = RAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_w_sig,
  output logic [AW-1:0] ram_add_w,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_add_r,
  input  logic [DW-1:0] ram_dout
);

  logic [1:0]    wr_req, rd_req;
  logic [1:0]    wr_gnt, rd_gnt;
  logic          collide;
  logic [DW-1:0] rd_word;

  logic [1:0]    rvalid_q, rvalid_d;
  logic          bypass_q, bypass_d;
  logic [DW-1:0] byp_data_q, byp_data_d;

  // Requests are masked while in reset so no grant and no RAM write can
  // happen; this also keeps the arbiter pointers frozen until the edge.
  always_comb begin
    wr_req = {req1 &  we1, req0 &  we0} & {2{~rst}};
    rd_req = {req1 & ~we1, req0 & ~we0} & {2{~rst}};
  end

  rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  // Each client issues at most one operation, so at most one of its two
  // grant bits can be set.
  assign ack0 = wr_gnt[0] | rd_gnt[0];
  assign ack1 = wr_gnt[1] | rd_gnt[1];

  // RAM port muxes; all fields park at zero when the port is idle.
  always_comb begin
    ram_w_sig = 1'b0;
    ram_add_w = '0;
    ram_din   = '0;
    ram_add_r = '0;
    if (wr_gnt[0]) begin
      ram_w_sig = 1'b1;
      ram_add_w = addr0;
      ram_din   = wdata0;
    end else if (wr_gnt[1]) begin
      ram_w_sig = 1'b1;
      ram_add_w = addr1;
      ram_din   = wdata1;
    end
    if (rd_gnt[0]) begin
      ram_add_r = addr0;
    end else if (rd_gnt[1]) begin
      ram_add_r = addr1;
    end
  end

  // The RAM returns pre-write data on a same-cycle address match, so the
  // write data is captured here and substituted in the response cycle.
  assign collide = ram_w_sig && (|rd_gnt) && (ram_add_w == ram_add_r);

  always_comb begin
    rvalid_d   = rd_gnt;
    bypass_d   = collide;
    byp_data_d = collide ? ram_din : byp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q   <= 2'b00;
      bypass_q   <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      bypass_q   <= bypass_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Gating with rst drops a response whose read was accepted in the cycle
  // just before reset was raised.
  assign rd_word = bypass_q ? byp_data_q : ram_dout;
  assign rvalid0 = rvalid_q[0] & ~rst;
  assign rvalid1 = rvalid_q[1] & ~rst;
  assign rdata0  = rvalid0 ? rd_word : '0;
  assign rdata1  = rvalid1 ? rd_word : '0;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_arbiter
// Purpose: Self-checking bench for ram_arbiter. A RAM model sits on the RAM
//          port; a behavioural model predicts every output each cycle, and
//          directed steps pin hand-computed values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_w_sig;
  logic [7:0] ram_add_w, ram_din, ram_add_r;
  logic [7:0] ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.DW(8), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_w_sig (ram_w_sig),
    .ram_add_w (ram_add_w),
    .ram_din   (ram_din),
    .ram_add_r (ram_add_r),
    .ram_dout  (ram_dout)
  );

  // RAM: synchronous write, registered read returning pre-write contents.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_w_sig) mem[ram_add_w] <= ram_din;
    ram_dout <= mem[ram_add_r];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int pick(input bit r0, input bit r1, input int ptr);
    if (r0 && r1) return ptr;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  initial begin
    logic [7:0] ref_mem [256];
    int         wptr, rptr, wg, rg;
    bit         pend_v;
    int         pend_c;
    logic [7:0] pend_d;
    logic [7:0] a [2];
    logic [7:0] d [2];
    bit         rq_w [2];
    bit         rq_r [2];
    bit         in_rst;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    wptr = 0; rptr = 0; pend_v = 0; pend_c = 0; pend_d = 8'h00;
    forever begin
      @(negedge clk);
      in_rst  = (rst === 1'b1);
      a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
      rq_w[0] = req0 && we0 && !in_rst;  rq_w[1] = req1 && we1 && !in_rst;
      rq_r[0] = req0 && !we0 && !in_rst; rq_r[1] = req1 && !we1 && !in_rst;
      wg = pick(rq_w[0], rq_w[1], wptr);
      rg = pick(rq_r[0], rq_r[1], rptr);

      chk("m_ack0", ack0, (wg == 0 || rg == 0));
      chk("m_ack1", ack1, (wg == 1 || rg == 1));
      chk("m_ram_w_sig", ram_w_sig, (wg >= 0));
      chk("m_ram_add_w", ram_add_w, (wg >= 0) ? a[wg] : 8'h00);
      chk("m_ram_din",   ram_din,   (wg >= 0) ? d[wg] : 8'h00);
      chk("m_ram_add_r", ram_add_r, (rg >= 0) ? a[rg] : 8'h00);
      chk("m_rvalid0", rvalid0, (pend_v && pend_c == 0 && !in_rst));
      chk("m_rvalid1", rvalid1, (pend_v && pend_c == 1 && !in_rst));
      chk("m_rdata0", rdata0, (pend_v && pend_c == 0 && !in_rst) ? pend_d : 8'h00);
      chk("m_rdata1", rdata1, (pend_v && pend_c == 1 && !in_rst) ? pend_d : 8'h00);

      @(posedge clk);
      if (in_rst) begin
        wptr = 0; rptr = 0; pend_v = 0;
      end else begin
        // Write-first: a same-cycle read sees the value written this cycle.
        if (wg >= 0) begin
          ref_mem[a[wg]] = d[wg];
          wptr = 1 - wg;
        end
        pend_v = (rg >= 0);
        if (rg >= 0) begin
          pend_c = rg;
          pend_d = ref_mem[a[rg]];
          rptr   = 1 - rg;
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic drive(input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_next();
  endtask

  initial begin
    rst = 1'b1;
    drive(1, 1, 8'h70, 8'h01, 1, 1, 8'h71, 8'h02);
    for (int i = 0; i < 2; i++) begin
      to_neg();
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_w_sig", ram_w_sig, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      to_next();
    end
    rst = 1'b0;
    to_neg();
    chk("first_grant_ack0", ack0, 1);
    chk("first_grant_ack1", ack1, 0);
    to_next();
    idle(); cyc();

    // Single write then read by client 0.
    drive(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
    to_neg(); chk("single_wr_ack0", ack0, 1); to_next();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    to_neg(); chk("single_rd_ack0", ack0, 1); chk("single_rd_rvalid_early", rvalid0, 0); to_next();
    idle();
    to_neg(); chk("single_rvalid0", rvalid0, 1); chk("single_rdata0", rdata0, 8'hA5); to_next();

    // Back to pointer 0 for the contention pattern.
    rst = 1'b1; cyc(); rst = 1'b0;

    drive(1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22);
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("contend_ack0", ack0, (i % 2 == 0));
      chk("contend_ack1", ack1, (i % 2 == 1));
      to_next();
    end
    drive(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00); cyc();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h21, 8'h00);
    to_neg(); chk("contend_rd0", rdata0, 8'h11); to_next();
    idle();
    to_neg(); chk("contend_rd1", rdata1, 8'h22); to_next();

    // Parallel ports.
    drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h3C); cyc();
    drive(1, 1, 8'h30, 8'h5A, 1, 0, 8'h40, 8'h00);
    to_neg(); chk("par_ack0", ack0, 1); chk("par_ack1", ack1, 1); to_next();
    idle();
    to_neg(); chk("par_rvalid1", rvalid1, 1); chk("par_rdata1", rdata1, 8'h3C);
    chk("par_rvalid0", rvalid0, 0); to_next();

    // Collision bypass, then read of the address written the cycle before.
    drive(1, 1, 8'h50, 8'hEE, 1, 0, 8'h50, 8'h00);
    to_neg(); chk("coll_w_sig", ram_w_sig, 1); chk("coll_ack1", ack1, 1); to_next();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h50, 8'h00);
    to_neg(); chk("coll_bypass_rdata1", rdata1, 8'hEE); to_next();
    idle();
    to_neg(); chk("after_wr_rdata1", rdata1, 8'hEE); to_next();

    // Reset while a read response is in flight.
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
    to_neg(); chk("midrst_ack1", ack1, 1); to_next();
    rst = 1'b1; idle();
    to_neg(); chk("midrst_rvalid1_t1", rvalid1, 0); chk("midrst_rdata1_t1", rdata1, 0); to_next();
    rst = 1'b0;
    to_neg(); chk("midrst_rvalid1_t2", rvalid1, 0); to_next();
    drive(1, 1, 8'h60, 8'h01, 1, 1, 8'h61, 8'h02);
    to_neg(); chk("midrst_wptr_ack0", ack0, 1); chk("midrst_wptr_ack1", ack1, 0); to_next();
    drive(1, 0, 8'h60, 8'h00, 1, 0, 8'h61, 8'h00);
    to_neg(); chk("midrst_rptr_ack0", ack0, 1); chk("midrst_rptr_ack1", ack1, 0); to_next();
    idle();
    to_neg(); chk("final_rdata0", rdata0, 8'h01); to_next();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
